// File: rtl/mips.sv
// Single-cycle MIPS core (addu/subu/ori/lw/sw/beq/lui/j/jal/jr) with
// word-addressed instruction and data memories. Every instruction retires in one clk.

module im #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  logic [31:0] Instr_memory [0:MEM_WORDS-1];

  // NOTE: memory arrays get no reset, so preloaded contents survive it; sequential
  // state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (load_en) Instr_memory[load_addr] <= load_data;
  end

  assign instr = Instr_memory[addr];
endmodule

module dm #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] Ram [0:MEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (we) Ram[addr] <= wdata;
  end

  assign rdata = Ram[addr];
endmodule

module mips #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int          MEM_WORDS = 1024
) (
  input logic clk,
  input logic reset
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_ORI     = 6'h0d,
    OP_LUI     = 6'h0f,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23
  } funct_e;

  logic [31:0]   pc, pc_plus4, next_pc, instr;
  opcode_e       opcode;
  funct_e        funct;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   instr_index;
  logic [31:0]   imm_sext, imm_zext, rs_val, rt_val;
  logic [31:0]   mem_addr, mem_rdata;
  logic [AW-1:0] im_addr, mem_idx;
  logic          rf_we, store, mem_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [31:0]   regs [0:31];

  assign pc_plus4 = pc + 32'd4;
  // Word index relative to the reset vector; upper bits wrap inside the memory.
  assign im_addr  = AW'((pc - PC_RESET) >> 2);

  im #(.MEM_WORDS(MEM_WORDS), .AW(AW)) myIM (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .addr      (im_addr),
    .instr     (instr)
  );

  assign opcode      = opcode_e'(instr[31:26]);
  assign funct       = funct_e'(instr[5:0]);
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign imm         = instr[15:0];
  assign instr_index = instr[25:0];
  assign imm_sext    = {{16{imm[15]}}, imm};
  assign imm_zext    = {16'h0000, imm};

  assign rs_val   = regs[rs];
  assign rt_val   = regs[rt];
  assign mem_addr = rs_val + imm_sext;
  assign mem_idx  = AW'(mem_addr >> 2);
  // A store in flight when reset falls must not land in memory.
  assign mem_we   = store & reset;

  dm #(.MEM_WORDS(MEM_WORDS), .AW(AW)) my_DM (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and every output gets a
    // default first so no decode path can infer a latch.
    next_pc  = pc_plus4;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = '0;
    store    = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU: begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rs_val + rt_val; end
          FN_SUBU: begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rs_val - rt_val; end
          FN_JR:   next_pc = rs_val;
          default: ;
        endcase
      end
      OP_ORI:  begin rf_we = 1'b1; rf_wdata = rs_val | imm_zext; end
      OP_LUI:  begin rf_we = 1'b1; rf_wdata = {imm, 16'h0000}; end
      OP_LW:   begin rf_we = 1'b1; rf_wdata = mem_rdata; end
      OP_SW:   store = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) next_pc = pc_plus4 + (imm_sext << 2);
      OP_J:    next_pc = {pc[31:28], instr_index, 2'b00};
      OP_JAL: begin
        next_pc  = {pc[31:28], instr_index, 2'b00};
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc_plus4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= PC_RESET;
    else        pc <= next_pc;
  end

  // $0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      if (rf_we && rf_waddr != 5'd0) $display("@%h: $%0d <= %h", pc, rf_waddr, rf_wdata);
      if (mem_we) $display("@%h: *%h <= %h", pc, mem_addr, rt_val);
    end
  end
`endif

endmodule

// File: tb/tb_mips.sv
// Bench for mips: directed program table, reset corner sequence, and random
// programs run in lock-step against an instruction-level model.

module tb_mips;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam int          MEM_WORDS = 1024;
  localparam int          AW        = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mips #(.PC_RESET(PC_RESET), .MEM_WORDS(MEM_WORDS)) dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] f_r(int d, int s, int t, logic [5:0] fn);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, fn};
  endfunction
  function automatic logic [31:0] f_i(logic [5:0] op, int s, int t, logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction
  function automatic logic [31:0] f_addu(int d, int s, int t); return f_r(d, s, t, 6'h21); endfunction
  function automatic logic [31:0] f_subu(int d, int s, int t); return f_r(d, s, t, 6'h23); endfunction
  function automatic logic [31:0] f_jr(int s);                 return f_r(0, s, 0, 6'h08); endfunction
  function automatic logic [31:0] f_ori(int t, int s, logic [15:0] imm); return f_i(6'h0d, s, t, imm); endfunction
  function automatic logic [31:0] f_lui(int t, logic [15:0] imm);        return f_i(6'h0f, 0, t, imm); endfunction
  function automatic logic [31:0] f_lw(int t, logic [15:0] off, int b);  return f_i(6'h23, b, t, off); endfunction
  function automatic logic [31:0] f_sw(int t, logic [15:0] off, int b);  return f_i(6'h2b, b, t, off); endfunction
  function automatic logic [31:0] f_beq(int s, int t, logic [15:0] off); return f_i(6'h04, s, t, off); endfunction
  function automatic logic [31:0] f_j(logic [31:0] target);   return {6'h02, target[27:2]}; endfunction
  function automatic logic [31:0] f_jal(logic [31:0] target); return {6'h03, target[27:2]}; endfunction

  // Instruction-level reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_ram  [MEM_WORDS];
  logic [31:0] m_im   [MEM_WORDS];
  logic [31:0] m_pc;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = PC_RESET;
  endtask

  task automatic model_step();
    logic [31:0] w, a, b, se, npc, wv;
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d, wr;
    logic        has_wr;
    logic [AW-1:0] widx;
    w      = m_im[AW'(((m_pc - PC_RESET) >> 2) % MEM_WORDS)];
    op     = w[31:26];
    fn     = w[5:0];
    s      = w[25:21];
    t      = w[20:16];
    d      = w[15:11];
    a      = m_regs[s];
    b      = m_regs[t];
    se     = {{16{w[15]}}, w[15:0]};
    npc    = m_pc + 32'd4;
    widx   = AW'(((a + se) >> 2) % MEM_WORDS);
    has_wr = 1'b0;
    wr     = '0;
    wv     = '0;
    if (op == 6'h00 && fn == 6'h21)      begin has_wr = 1'b1; wr = d; wv = a + b; end
    else if (op == 6'h00 && fn == 6'h23) begin has_wr = 1'b1; wr = d; wv = a - b; end
    else if (op == 6'h00 && fn == 6'h08) npc = a;
    else if (op == 6'h0d) begin has_wr = 1'b1; wr = t; wv = a | {16'h0, w[15:0]}; end
    else if (op == 6'h0f) begin has_wr = 1'b1; wr = t; wv = {w[15:0], 16'h0}; end
    else if (op == 6'h23) begin has_wr = 1'b1; wr = t; wv = m_ram[widx]; end
    else if (op == 6'h2b) m_ram[widx] = b;
    else if (op == 6'h04) begin if (a == b) npc = m_pc + 32'd4 + (se << 2); end
    else if (op == 6'h02) npc = {m_pc[31:28], w[25:0], 2'b00};
    else if (op == 6'h03) begin
      npc = {m_pc[31:28], w[25:0], 2'b00};
      has_wr = 1'b1; wr = 5'd31; wv = m_pc + 32'd4;
    end
    if (has_wr && wr != 5'd0) m_regs[wr] = wv;
    m_pc = npc;
  endtask

  task automatic load_program(input logic [31:0] words [$]);
    logic [31:0] w;
    for (int i = 0; i < MEM_WORDS; i++) begin
      w = (i < words.size()) ? words[i] : 32'h0;
      dut.myIM.Instr_memory[i] = w;
      m_im[i] = w;
    end
  endtask

  task automatic fill_ram(input logic randomize);
    logic [31:0] v;
    for (int i = 0; i < MEM_WORDS; i++) begin
      v = randomize ? $urandom : 32'h0;
      dut.my_DM.Ram[i] = v;
      m_ram[i] = v;
    end
  endtask

  // Directed vectors
  typedef struct {
    string            name;
    logic [0:7][31:0] prog;
    int               cycles;
    int               ra;
    logic [31:0]      ra_exp;
    int               rb;
    logic [31:0]      rb_exp;
    int               mem_idx;
    logic [31:0]      mem_exp;
    logic [31:0]      pc_exp;
  } vec_t;

  function automatic vec_t mk(string name, logic [0:7][31:0] prog, int cycles,
                              int ra, logic [31:0] ra_exp, int rb, logic [31:0] rb_exp,
                              int mem_idx, logic [31:0] mem_exp, logic [31:0] pc_exp);
    vec_t v;
    v.name = name; v.prog = prog; v.cycles = cycles;
    v.ra = ra; v.ra_exp = ra_exp; v.rb = rb; v.rb_exp = rb_exp;
    v.mem_idx = mem_idx; v.mem_exp = mem_exp; v.pc_exp = pc_exp;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [31:0] q [$];
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back(v.prog[i]);
    load_program(q);
    fill_ram(1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (v.cycles) @(negedge clk);
    check({v.name, "_ra"},  dut.regs[v.ra], v.ra_exp);
    check({v.name, "_rb"},  dut.regs[v.rb], v.rb_exp);
    check({v.name, "_mem"}, dut.my_DM.Ram[v.mem_idx], v.mem_exp);
    check({v.name, "_pc"},  dut.pc, v.pc_exp);
  endtask

  // Random program generation
  function automatic int rand_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 31 : r;
  endfunction

  function automatic logic [31:0] rand_instr(int prog_len);
    logic [31:0] tgt;
    logic [15:0] imm;
    imm = 16'($urandom);
    tgt = PC_RESET + 32'(4 * $urandom_range(0, prog_len - 1));
    case ($urandom_range(0, 12))
      0, 1:    return f_addu(rand_reg(), rand_reg(), rand_reg());
      2:       return f_subu(rand_reg(), rand_reg(), rand_reg());
      3, 4:    return f_ori(rand_reg(), rand_reg(), imm);
      5:       return f_lui(rand_reg(), imm);
      6:       return f_lw(rand_reg(), imm, rand_reg());
      7:       return f_sw(rand_reg(), imm, rand_reg());
      8:       return f_beq(rand_reg(), rand_reg(), 16'($urandom_range(0, 10)) - 16'd5);
      9:       return f_j(tgt);
      10:      return f_jal(tgt);
      11:      return f_jr(($urandom_range(0, 3) == 0) ? rand_reg() : 31);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_random(input int prog_len, input int cycles);
    logic [31:0] q [$];
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < prog_len; i++) q.push_back(rand_instr(prog_len));
    load_program(q);
    fill_ram(1'b1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rand_pc", dut.pc, m_pc);
      for (int r = 0; r < 32; r++) check($sformatf("rand_r%0d", r), dut.regs[r], m_regs[r]);
    end
    for (int i = 0; i < MEM_WORDS; i++) check($sformatf("rand_ram%0d", i), dut.my_DM.Ram[i], m_ram[i]);
  endtask

  initial begin
    vec_t        vecs [$];
    logic [31:0] q [$];
    int          nz;

    vecs.push_back(mk("rst_state", {8{32'h0}}, 0, 31, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0000_3000));
    vecs.push_back(mk("ori_lui", {f_ori(1, 0, 16'h1234), f_lui(2, 16'hABCD), {6{32'h0}}},
                      2, 1, 32'h0000_1234, 2, 32'hABCD_0000, 0, 32'h0, 32'h0000_3008));
    vecs.push_back(mk("addu_wrap", {f_lui(1, 16'hFFFF), f_ori(1, 1, 16'hFFFF), f_ori(2, 0, 16'h0001),
                      f_addu(3, 1, 2), {4{32'h0}}},
                      4, 3, 32'h0, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0000_3010));
    vecs.push_back(mk("subu_wrap", {f_lui(1, 16'hFFFF), f_ori(1, 1, 16'hFFFF), f_ori(2, 0, 16'h0001),
                      f_subu(4, 2, 1), {4{32'h0}}},
                      4, 4, 32'h2, 2, 32'h1, 0, 32'h0, 32'h0000_3010));
    vecs.push_back(mk("sw_lw", {f_ori(1, 0, 16'h1234), f_sw(1, 16'h0004, 0), f_lw(3, 16'h0004, 0),
                      f_ori(0, 0, 16'h0005), {4{32'h0}}},
                      4, 3, 32'h1234, 0, 32'h0, 1, 32'h1234, 32'h0000_3010));
    vecs.push_back(mk("beq_self", {f_beq(0, 0, 16'hFFFF), {7{32'h0}}},
                      3, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0000_3000));
    vecs.push_back(mk("beq_ne", {f_ori(1, 0, 16'h0001), f_beq(1, 0, 16'h0010), {6{32'h0}}},
                      2, 1, 32'h1, 2, 32'h0, 0, 32'h0, 32'h0000_3008));
    vecs.push_back(mk("beq_fwd", {f_ori(1, 0, 16'h0007), f_ori(2, 0, 16'h0007), f_beq(1, 2, 16'h0002),
                      f_ori(3, 0, 16'h0009), f_ori(4, 0, 16'h0001), f_ori(5, 0, 16'h0003), {2{32'h0}}},
                      4, 5, 32'h3, 3, 32'h0, 0, 32'h0, 32'h0000_3018));
    vecs.push_back(mk("jal", {32'h0, 32'h0, f_jal(32'h0000_3010), 32'h0, f_jr(31), {3{32'h0}}},
                      3, 31, 32'h0000_300C, 0, 32'h0, 0, 32'h0, 32'h0000_3010));
    vecs.push_back(mk("jal_jr", {32'h0, 32'h0, f_jal(32'h0000_3010), 32'h0, f_jr(31), {3{32'h0}}},
                      4, 31, 32'h0000_300C, 1, 32'h0, 0, 32'h0, 32'h0000_300C));
    vecs.push_back(mk("j", {f_j(32'h0000_3018), f_ori(1, 0, 16'h0001), {4{32'h0}},
                      f_ori(2, 0, 16'h0002), 32'h0},
                      2, 1, 32'h0, 2, 32'h2, 0, 32'h0, 32'h0000_301C));
    vecs.push_back(mk("undef", {f_ori(2, 0, 16'h0003), f_i(6'h08, 2, 1, 16'h0005),
                      f_r(3, 2, 2, 6'h20), {5{32'h0}}},
                      3, 1, 32'h0, 3, 32'h0, 0, 32'h0, 32'h0000_300C));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Mid-program reset pulse: immediate PC/register clear, no store under reset.
    @(negedge clk);
    reset = 1'b0;
    q = {f_sw(7, 16'h0008, 0), f_ori(1, 0, 16'h1234), f_sw(1, 16'h0004, 0),
         f_ori(7, 0, 16'h0077), f_beq(0, 0, 16'hFFFF)};
    load_program(q);
    fill_ram(1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("prog_pc",  dut.pc, 32'h0000_3010);
    check("prog_r7",  dut.regs[7], 32'h77);
    check("prog_ram", dut.my_DM.Ram[1], 32'h1234);
    dut.my_DM.Ram[2] = 32'hDEAD_BEEF;
    #1 reset = 1'b0;
    #1;
    check("rst_async_pc", dut.pc, PC_RESET);
    nz = 0;
    for (int r = 0; r < 32; r++) if (dut.regs[r] !== 32'h0) nz++;
    check("rst_async_regs_nonzero", 32'(nz), 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_pc",     dut.pc, PC_RESET);
    check("rst_edge_r1",     dut.regs[1], 32'h0);
    check("rst_no_store",    dut.my_DM.Ram[2], 32'hDEAD_BEEF);
    check("rst_ram_kept",    dut.my_DM.Ram[1], 32'h1234);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_pc",    dut.pc, 32'h0000_3004);
    check("post_rst_store", dut.my_DM.Ram[2], 32'h0);

    for (int p = 0; p < 3; p++) run_random(48, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips.md
MIPS -- requirements
Module: mips

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter MEM_WORDS, default 1024: depth of the instruction and data memories, in 32-bit words.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 The design SHALL have no other ports.
REQ-006 Instruction memory SHALL be instance myIM, holding array Instr_memory[0:MEM_WORDS-1] of 32 bits, so the bench can load it hierarchically with $readmemh.
REQ-007 Data memory SHALL be instance my_DM, holding array Ram[0:MEM_WORDS-1] of 32 bits, hierarchically loadable the same way.

Function
REQ-008 The design SHALL be a single-cycle MIPS core: one instruction fetched, executed and retired per clk cycle.
REQ-009 Fetch: instruction = Instr_memory[(PC - PC_RESET)[11:2]]; combinational read.
REQ-010 Supported instructions: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, and nop (all-zero word).
REQ-011 Any other encoding SHALL execute as nop (PC+4, no state change).
REQ-012 addu/subu: rd <= rs +/- rt, modulo 2^32, no overflow trap.
REQ-013 ori: rt <= rs | zero-extended imm16.
REQ-014 lui: rt <= {imm16, 16'h0}.
REQ-015 lw: rt <= Ram[(rs + sign-extended imm16)[11:2]]; combinational read.
REQ-016 sw: Ram[(rs + sign-extended imm16)[11:2]] <= rt on the rising edge.
REQ-017 Address bits [1:0] SHALL be ignored; bits above [11] SHALL wrap, so there is no fault.
REQ-018 beq: if rs == rt then PC <= PC + 4 + (sign-extended imm16 << 2), else PC + 4.
REQ-019 j: PC <= {PC[31:28], instr_index, 2'b00}.
REQ-020 jal: same target as j, and $31 <= PC + 4.
REQ-021 jr: PC <= rs.
REQ-022 All other instructions SHALL set PC <= PC + 4; the PC wraps at 2^32.
REQ-023 Register file: 32 x 32 bits, two combinational read ports and one write port written on the rising edge.
REQ-024 Writes to $0 SHALL be discarded, and $0 SHALL always read 0.
REQ-025 A read of a register written in the same cycle SHALL return the old value; the new value is visible the next cycle.
REQ-026 Simulation trace: every register write to a non-zero register SHALL $display "@<PC hex>: $<reg dec> <= <data hex>".
REQ-027 Simulation trace: every store SHALL $display "@<PC hex>: *<addr hex> <= <data hex>".

Reset
REQ-028 While reset == 0, PC SHALL be PC_RESET immediately, without waiting for a clock edge.
REQ-029 While reset == 0, all 32 registers SHALL read 0.
REQ-030 While reset == 0, no memory write SHALL occur.
REQ-031 Reset SHALL NOT alter Instr_memory or Ram, so preloaded contents survive reset.
REQ-032 Asserting reset mid-instruction SHALL abort that instruction's write-back.
REQ-033 The first edge after reset deasserts SHALL execute the instruction at PC_RESET.

Verification
REQ-034 Bench loads ori $1,$0,0x1234 then lui $2,0xABCD, then releases reset -> $1 = 0x00001234 and $2 = 0xABCD0000 after 2 cycles; trace shows @00003000 and @00003004.
REQ-035 addu/subu with $1 = 0xFFFFFFFF and $2 = 1 -> addu gives 0x00000000, subu $2-$1 gives 0x00000002.
REQ-036 sw $1,4($0) with $1 = 0x1234, then lw $3,4($0) -> Ram[1] = 0x1234 and $3 = 0x1234; ori $0,$0,5 leaves $0 = 0.
REQ-037 beq $0,$0,-1 at 0x3000 -> PC stays 0x3000 every cycle; beq with unequal operands -> PC advances to 0x3004.
REQ-038 jal to 0x3010 placed at 0x3008 -> $31 = 0x300C and PC = 0x3010; a following jr $31 -> PC = 0x300C.
REQ-039 Drive reset low for half a cycle mid-program -> PC = 0x3000 and all registers 0 with no clock edge; Ram contents unchanged.
